// File: rtl/block_transfer_controller_pkg.sv
// Shared types and default parameters for the block transfer controller.
// The state enum is kept here so that the top level and any future
// monitors agree on one encoding.
package block_transfer_package;

  // Default geometry: 128 blocks of 8 words, 32-bit word addresses and data.
  localparam int DEFAULT_ADDRESS_WIDTH    = 32;
  localparam int DEFAULT_DATA_WIDTH       = 32;
  localparam int DEFAULT_NUMBER_OF_BLOCKS = 128;
  localparam int DEFAULT_WORDS_PER_BLOCK  = 8;

  // Controller sequencing states.
  //   IDLE    : accepting a request
  //   ACCESS  : one RAM word access in flight, waiting for completion
  //   RELEASE : enables dropped for one cycle so the RAM re-arms its delay
  //   DONE    : completion pulse
  //   ERROR   : out-of-range block pulse, no RAM traffic
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    RELEASE = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } state_t;

endpackage

// File: rtl/block_transfer_controller_word_counter.sv
// Word-within-block counter. Loaded to zero when a request is accepted,
// stepped once per completed word, and never wraps inside a transfer:
// an increment request while already on the last word is ignored.
module word_counter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int WIDTH           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             increment,
  output logic [WIDTH-1:0] index,
  output logic             last
);

  localparam logic [WIDTH-1:0] LAST_INDEX = WIDTH'(WORDS_PER_BLOCK - 1);

  // Counter register: clear on reset or load, step on increment below the last word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      index <= '0;
    end else if (load) begin
      index <= '0;
    end else if (increment && !last) begin
      index <= index + 1'b1;
    end
  end

  assign last = (index == LAST_INDEX);

endmodule

// File: rtl/block_transfer_controller.sv
// Block transfer controller: moves one cache block between the cache and a
// word-wide RAM, one word per RAM handshake. Fills stream each word back to
// the cache as a fillValid pulse; write-backs take the cache word for the
// current wordIndex combinationally. Out-of-range blocks are rejected with
// an error pulse before any RAM enable is raised.
module block_transfer_controller
  import block_transfer_package::*;
#(
  parameter int ADDRESS_WIDTH    = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int NUMBER_OF_BLOCKS = DEFAULT_NUMBER_OF_BLOCKS,
  parameter int WORDS_PER_BLOCK  = DEFAULT_WORDS_PER_BLOCK
) (
  input  logic                               clock,
  input  logic                               reset,
  // Cache request side
  input  logic                               requestValid,
  input  logic                               requestWrite,
  input  logic [ADDRESS_WIDTH-1:0]           requestBlock,
  output logic                               requestReady,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] wordIndex,
  input  logic [DATA_WIDTH-1:0]              writeWordData,
  output logic                               fillValid,
  output logic [DATA_WIDTH-1:0]              fillData,
  output logic                               done,
  output logic                               error,
  // RAM master side
  output logic [ADDRESS_WIDTH-1:0]           ramAddress,
  output logic [DATA_WIDTH-1:0]              ramDataOut,
  input  logic [DATA_WIDTH-1:0]              ramDataIn,
  output logic                               ramReadEnabled,
  output logic                               ramWriteEnabled,
  input  logic                               ramFunctionComplete
);

  localparam int WORD_BITS = $clog2(WORDS_PER_BLOCK);

  state_t                   state;
  state_t                   state_next;
  logic                     latched_write;
  logic [ADDRESS_WIDTH-1:0] latched_block;
  logic                     block_in_range;
  logic                     accept;
  logic                     counter_load;
  logic                     counter_increment;
  logic                     counter_last;

  // Range check is done on the raw request so it precedes any RAM access.
  assign block_in_range = (requestBlock < ADDRESS_WIDTH'(NUMBER_OF_BLOCKS));

  // State register; reset drops straight to IDLE so the enables fall at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture direction and block only on the accepting edge; later requests are ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      latched_write <= 1'b0;
      latched_block <= '0;
    end else if (accept) begin
      latched_write <= requestWrite;
      latched_block <= requestBlock;
    end
  end

  // Next-state and per-state outputs; everything defaults inactive.
  always_comb begin
    state_next        = state;
    requestReady      = 1'b0;
    ramReadEnabled    = 1'b0;
    ramWriteEnabled   = 1'b0;
    fillValid         = 1'b0;
    done              = 1'b0;
    error             = 1'b0;
    accept            = 1'b0;
    counter_load      = 1'b0;
    counter_increment = 1'b0;
    case (state)
      IDLE: begin
        requestReady = 1'b1;
        if (requestValid) begin
          accept       = 1'b1;
          counter_load = 1'b1;
          state_next   = block_in_range ? ACCESS : ERROR;
        end
      end
      ACCESS: begin
        ramReadEnabled  = !latched_write;
        ramWriteEnabled = latched_write;
        if (ramFunctionComplete) begin
          fillValid  = !latched_write;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        // Enables are low here for exactly one cycle between words.
        if (counter_last) begin
          state_next = DONE;
        end else begin
          counter_increment = 1'b1;
          state_next        = ACCESS;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERROR: begin
        error      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Word position inside the block.
  word_counter #(
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .WIDTH           (WORD_BITS)
  ) u_word_counter (
    .clock     (clock),
    .reset     (reset),
    .load      (counter_load),
    .increment (counter_increment),
    .index     (wordIndex),
    .last      (counter_last)
  );

  // Word address wraps modulo 2^ADDRESS_WIDTH like the RAM port itself.
  assign ramAddress = latched_block * ADDRESS_WIDTH'(WORDS_PER_BLOCK)
                    + ADDRESS_WIDTH'(wordIndex);
  assign ramDataOut = writeWordData;
  assign fillData   = ramDataIn;

endmodule

// File: tb/tb_block_transfer_controller.sv
// Self-checking bench for block_transfer_controller: a RAM model with a
// fixed completion delay, a directed vector table, two multi-cycle corner
// sequences (mid-transfer reset, request during transfer) and randomized
// transfers checked against a block-level memory model.
`timescale 1ns/1ps
module tb_block_transfer_controller;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int NB         = 128;
  localparam int WPB        = 8;
  localparam int RAM_DELAY  = 4;
  localparam int RAM_WORDS  = NB * WPB;
  localparam int XFER_DONE  = WPB * (RAM_DELAY + 2) + 1;   // 49
  localparam int WINDOW     = 110;

  logic          clock = 1'b0;
  logic          reset;
  logic          requestValid;
  logic          requestWrite;
  logic [AW-1:0] requestBlock;
  logic          requestReady;
  logic [2:0]    wordIndex;
  logic [DW-1:0] writeWordData;
  logic          fillValid;
  logic [DW-1:0] fillData;
  logic          done;
  logic          error;
  logic [AW-1:0] ramAddress;
  logic [DW-1:0] ramDataOut;
  logic [DW-1:0] ramDataIn;
  logic          ramReadEnabled;
  logic          ramWriteEnabled;
  logic          ramFunctionComplete;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  block_transfer_controller #(
    .ADDRESS_WIDTH    (AW),
    .DATA_WIDTH       (DW),
    .NUMBER_OF_BLOCKS (NB),
    .WORDS_PER_BLOCK  (WPB)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .requestValid        (requestValid),
    .requestWrite        (requestWrite),
    .requestBlock        (requestBlock),
    .requestReady        (requestReady),
    .wordIndex           (wordIndex),
    .writeWordData       (writeWordData),
    .fillValid           (fillValid),
    .fillData            (fillData),
    .done                (done),
    .error               (error),
    .ramAddress          (ramAddress),
    .ramDataOut          (ramDataOut),
    .ramDataIn           (ramDataIn),
    .ramReadEnabled      (ramReadEnabled),
    .ramWriteEnabled     (ramWriteEnabled),
    .ramFunctionComplete (ramFunctionComplete)
  );

  // Cache side: the word at wordIndex is presented combinationally.
  logic [DW-1:0] cache_words [WPB];
  assign writeWordData = cache_words[wordIndex];

  // RAM model: completes after the enable has been held for RAM_DELAY cycles.
  logic [DW-1:0] ram [RAM_WORDS];
  logic [DW-1:0] ref_mem [RAM_WORDS];
  logic          preload;
  int            ram_delay;
  logic          ram_en;

  assign ram_en              = ramReadEnabled | ramWriteEnabled;
  assign ramFunctionComplete = ram_en && (ram_delay == RAM_DELAY);
  assign ramDataIn           = ram[ramAddress[9:0]];

  always @(posedge clock or negedge reset) begin
    if (!reset) ram_delay <= 0;
    else if (!ram_en) ram_delay <= 0;
    else if (ram_delay != RAM_DELAY) ram_delay <= ram_delay + 1;
  end

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= 32'h100 + i;
    end else if (ramWriteEnabled && ramFunctionComplete) begin
      ram[ramAddress[9:0]] <= ramDataOut;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ram_image(input string name);
    int bad = 0;
    for (int i = 0; i < RAM_WORDS; i++) if (ram[i] !== ref_mem[i]) bad++;
    check(name, bad, 0);
  endtask

  // One complete transaction. hold > 0 keeps a conflicting request asserted
  // for that many cycles after acceptance.
  task automatic run_txn(input string tag, input logic wr, input logic [AW-1:0] blk,
                         input int hold, input logic exp_err, input int exp_done);
    int   done_cyc = -1, err_cyc = -1, done_n = 0, both_n = 0, rel_viol = 0;
    int   dir_viol = 0, en_seen = 0, ready_busy = 0, ready_end = 0, bad = 0;
    int   exp_end;
    logic prev_cpl = 1'b0;
    logic en;
    logic [DW-1:0] fill_q[$];
    logic [DW-1:0] exp_fill[$];
    int            idx_q[$];

    exp_end = exp_err ? 1 : exp_done;
    if (!exp_err && !wr)
      for (int i = 0; i < WPB; i++) exp_fill.push_back(ref_mem[int'(blk) * WPB + i]);

    @(negedge clock);
    check({tag, ".ready_idle"}, requestReady, 1);
    requestValid = 1'b1;
    requestWrite = wr;
    requestBlock = blk;
    @(posedge clock);
    for (int cyc = 0; cyc < WINDOW; cyc++) begin
      @(negedge clock);
      en = ramReadEnabled | ramWriteEnabled;
      if (ramReadEnabled && ramWriteEnabled) both_n++;
      if (en) en_seen = 1;
      if (en && (ramWriteEnabled !== wr)) dir_viol++;
      if (prev_cpl && en) rel_viol++;
      prev_cpl = en && ramFunctionComplete;
      if (en && ramFunctionComplete) idx_q.push_back(int'(wordIndex));
      if (fillValid) fill_q.push_back(fillData);
      if (done) begin done_n++; if (done_cyc < 0) done_cyc = cyc + 1; end
      if (error && err_cyc < 0) err_cyc = cyc + 1;
      if (requestReady && cyc < exp_end) ready_busy++;
      if (cyc == exp_end) ready_end = int'(requestReady);
      if (cyc < hold) begin
        requestValid = 1'b1;
        requestWrite = ~wr;
        requestBlock = blk ^ 32'h1;
      end else begin
        requestValid = 1'b0;
      end
    end

    if (!exp_err && wr)
      for (int i = 0; i < WPB; i++) ref_mem[int'(blk) * WPB + i] = cache_words[i];

    check({tag, ".error_cycle"}, err_cyc, exp_err ? 1 : -1);
    check({tag, ".done_cycle"}, done_cyc, exp_err ? -1 : exp_done);
    check({tag, ".done_count"}, done_n, exp_err ? 0 : 1);
    check({tag, ".both_enables"}, both_n, 0);
    check({tag, ".release_gap"}, rel_viol, 0);
    check({tag, ".direction"}, dir_viol, 0);
    check({tag, ".ram_enabled"}, en_seen, exp_err ? 0 : 1);
    check({tag, ".ready_busy"}, ready_busy, 0);
    check({tag, ".ready_after"}, ready_end, 1);
    check({tag, ".fill_count"}, fill_q.size(), exp_fill.size());
    for (int i = 0; i < fill_q.size() && i < exp_fill.size(); i++)
      if (fill_q[i] !== exp_fill[i]) bad++;
    check({tag, ".fill_data"}, bad, 0);
    check({tag, ".word_count"}, idx_q.size(), exp_err ? 0 : WPB);
    bad = 0;
    for (int i = 0; i < idx_q.size(); i++) if (idx_q[i] != i) bad++;
    check({tag, ".word_order"}, bad, 0);
    check_ram_image({tag, ".ram_image"});
    $display("[TB] %s wr=%0d blk=0x%0h done@%0d err@%0d fills=%0d",
             tag, wr, blk, done_cyc, err_cyc, fill_q.size());
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] blk;
    logic [DW-1:0] cache_base;
    int            hold;
    logic          exp_err;
    int            exp_done;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int            found;
    int            n_done;
    int            n_en;
    logic          wr;
    logic [AW-1:0] blk;
    logic          err;

    vecs[0] = '{1'b0, 32'd3,          32'h0,        0,  1'b0, 49};
    vecs[1] = '{1'b1, 32'd0,          32'hA0,       0,  1'b0, 49};
    vecs[2] = '{1'b0, 32'd128,        32'h0,        0,  1'b1, -1};
    vecs[3] = '{1'b1, 32'd127,        32'hC0DE0000, 0,  1'b0, 49};
    vecs[4] = '{1'b0, 32'd127,        32'h0,        0,  1'b0, 49};
    vecs[5] = '{1'b0, 32'd0,          32'h0,        0,  1'b0, 49};
    vecs[6] = '{1'b1, 32'hFFFF_FFFF,  32'h0,        0,  1'b1, -1};
    vecs[7] = '{1'b0, 32'd3,          32'h0,        40, 1'b0, 49};
    vecs[8] = '{1'b1, 32'd64,         32'h77000000, 20, 1'b0, 49};

    reset        = 1'b0;
    requestValid = 1'b0;
    requestWrite = 1'b0;
    requestBlock = '0;
    preload      = 1'b1;
    for (int i = 0; i < WPB; i++) cache_words[i] = '0;
    for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = 32'h100 + i;

    repeat (3) @(negedge clock);
    check("reset.read_enable", ramReadEnabled, 0);
    check("reset.write_enable", ramWriteEnabled, 0);
    check("reset.word_index", wordIndex, 0);
    check("reset.fill_valid", fillValid, 0);
    check("reset.done", done, 0);
    check("reset.error", error, 0);
    preload = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    check("reset.ready_after_release", requestReady, 1);
    check_ram_image("reset.preload_image");

    // Directed vectors.
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < WPB; i++) cache_words[i] = vecs[v].cache_base + i;
      run_txn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].blk, vecs[v].hold,
              vecs[v].exp_err, vecs[v].exp_done);
    end

    // Reset asserted while word 4 of a write-back is in flight.
    for (int i = 0; i < WPB; i++) cache_words[i] = 32'h5500 + i;
    @(negedge clock);
    requestValid = 1'b1;
    requestWrite = 1'b1;
    requestBlock = 32'd5;
    @(posedge clock);
    @(negedge clock);
    requestValid = 1'b0;
    found = 0;
    for (int n = 0; n < 100; n++) begin
      if (wordIndex == 3'd4 && ramWriteEnabled) begin found = 1; break; end
      @(negedge clock);
    end
    check("rst_mid.reached_word4", found, 1);
    reset = 1'b0;
    #1;
    check("rst_mid.write_enable", ramWriteEnabled, 0);
    check("rst_mid.read_enable", ramReadEnabled, 0);
    check("rst_mid.word_index", wordIndex, 0);
    check("rst_mid.done", done, 0);
    for (int i = 0; i < 4; i++) ref_mem[5 * WPB + i] = cache_words[i];
    repeat (3) @(negedge clock);
    reset  = 1'b1;
    n_done = 0;
    n_en   = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clock);
      if (done) n_done++;
      if (ramReadEnabled || ramWriteEnabled) n_en++;
    end
    check("rst_mid.no_done", n_done, 0);
    check("rst_mid.no_access", n_en, 0);
    check_ram_image("rst_mid.ram_image");
    $display("[TB] rst_mid write blk=5 aborted at word 4");

    // Randomized transfers against the block-level memory model.
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) blk = 32'd128 + $urandom_range(0, 100000);
      else blk = 32'($urandom_range(0, NB - 1));
      err = (blk >= NB);
      for (int i = 0; i < WPB; i++) cache_words[i] = $urandom;
      run_txn($sformatf("rand%0d", t), wr, blk, 0, err, err ? -1 : XFER_DONE);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/block_transfer_controller.md
BLOCK_TRANSFER_CONTROLLER -- requirements
Module: block_transfer_controller

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, word-address width of the RAM port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-003 SHALL have parameter NUMBER_OF_BLOCKS, default 128, blocks held by RAM.
REQ-004 SHALL have parameter WORDS_PER_BLOCK, default 8 (power of two), words per block.
REQ-005 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port requestValid  input  1  cache requests a block transfer.
REQ-008 SHALL have port requestWrite  input  1  1 = write-back to RAM, 0 = fill from RAM.
REQ-009 SHALL have port requestBlock  input  ADDRESS_WIDTH  block index.
REQ-010 SHALL have port requestReady  output  1  controller idle and accepting.
REQ-011 SHALL have port wordIndex  output  log2(WORDS_PER_BLOCK)  current word within block.
REQ-012 SHALL have port writeWordData  input  DATA_WIDTH  cache word at wordIndex, combinational from cache.
REQ-013 SHALL have port fillValid  output  1  one-cycle pulse, fillData valid for wordIndex.
REQ-014 SHALL have port fillData  output  DATA_WIDTH  word read from RAM.
REQ-015 SHALL have port done  output  1  one-cycle pulse, transfer complete.
REQ-016 SHALL have port error  output  1  one-cycle pulse, requestBlock >= NUMBER_OF_BLOCKS.
REQ-017 SHALL have ports ramAddress (out, ADDRESS_WIDTH), ramDataOut (out, DATA_WIDTH), ramDataIn (in, DATA_WIDTH), ramReadEnabled (out, 1), ramWriteEnabled (out, 1), ramFunctionComplete (in, 1): master side of the RAM word port.

Function
REQ-018 SHALL implement states IDLE, ACCESS, RELEASE, DONE, ERROR.
REQ-019 IDLE: requestReady=1; on requestValid=1 SHALL latch requestWrite/requestBlock, clear word counter, go ACCESS (or ERROR if block out of range).
REQ-020 ACCESS: ramAddress SHALL equal latchedBlock*WORDS_PER_BLOCK + wordIndex; exactly one of ramReadEnabled/ramWriteEnabled high per latched direction.
REQ-021 ACCESS write: ramDataOut SHALL equal writeWordData combinationally.
REQ-022 ACCESS: SHALL stay until ramFunctionComplete=1; in that cycle, for reads, fillValid=1 and fillData=ramDataIn; then go RELEASE.
REQ-023 RELEASE: both RAM enables SHALL be 0 for exactly one cycle (re-arms RAM delay counter); if wordIndex=WORDS_PER_BLOCK-1 go DONE, else increment wordIndex, go ACCESS.
REQ-024 DONE: done=1 one cycle, then IDLE; ERROR: error=1 one cycle, no RAM enable, then IDLE.
REQ-025 requestValid outside IDLE SHALL be ignored (requestReady=0); requests never queued.
REQ-026 Per-word latency SHALL be RAM delay D+2 cycles; D=4, WORDS_PER_BLOCK=8 gives done 49 cycles after accepting edge.
REQ-027 wordIndex SHALL not wrap within a transfer; counts 0..WORDS_PER_BLOCK-1 strictly ascending.
REQ-028 Address arithmetic SHALL be ADDRESS_WIDTH bits; out-of-range check SHALL precede any RAM access.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, wordIndex=0, all RAM enables 0, fillValid/done/error 0, requestReady 1 after release.
REQ-030 Reset mid-transfer SHALL abort without done; partial RAM writes remain, no further access issued.

Structure
REQ-031 Package block_transfer_package SHALL hold the state enum type and default parameter constants.
REQ-032 Sub-module word_counter (load/increment/last flag) SHALL generate wordIndex; rest stays in top.

Verification
REQ-033 Fill block 3, RAM preloaded word n = 0x100+n, D=4 -> 8 fillValid pulses, data 0x118..0x11F, done at cycle 49.
REQ-034 Write-back block 0, writeWordData = 0xA0+wordIndex -> RAM words 0..7 = 0xA0..0xA7, done at cycle 49.
REQ-035 requestBlock=128 -> error pulse next cycle, ramReadEnabled/ramWriteEnabled never 1, back to IDLE.
REQ-036 Second requestValid asserted during transfer -> ignored, only one done pulse.
REQ-037 reset=0 at word 4 of a write-back -> enables drop same cycle, no done, RAM words 5..7 unchanged.
REQ-038 Every ACCESS->ACCESS gap checked -> at least one RELEASE cycle with both enables 0.
